// File: rtl/pbs_turn_ctrl.sv
// -----------------------------------------------------------------------------
// pbs_turn_ctrl
//
// Purpose
//   Turn sequencer for the battle datapath. A go edge in IDLE runs one full
//   turn. The player half-turn runs first and the AI half-turn follows. Each
//   half-turn is:
//     SEL (1) -> WAIT (SETTLE_CYCLES) -> HIT (1) -> APPLY (1) -> CHK (SETTLE_CYCLES)
//   A miss in HIT skips APPLY and CHK and moves straight on. The block counts
//   completed turns. It ends the game in OVER when one side faints (p_win or
//   ai_win) or when the turn limit is reached (draw).
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset; has priority over all inputs
//   go        in   player confirm level; only a rising edge starts a turn
//   accu      in   [4:0] accuracy of the selected move
//   acc_rng   in   [4:0] accuracy random value (bit 4 is always 0)
//   p_hp      in   [4:0] player HP
//   ai_hp     in   [4:0] AI HP
//   actr      out  trainer select (0 = player move, 1 = AI random move)
//   target    out  damage target (1 = AI, 0 = player)
//   app_dmg   out  one-cycle apply-damage strobe
//   stop      out  RNG freeze (1 = frozen) for the whole turn
//   busy      out  high in every state except IDLE and OVER
//   last_miss out  result of the most recent accuracy check
//   turn_cnt  out  [TURN_W-1:0] number of completed full turns
//   p_win     out  AI fainted
//   ai_win    out  player fainted
//   draw      out  turn limit reached with both sides alive
//
// Parameters
//   SETTLE_CYCLES  settle wait after move select and after apply (1..15)
//   TURN_W         width of the turn counter
//   MAX_TURNS      turn count that declares a draw; must be < 2**TURN_W
//
// Configuration macro
//   ACCURACY_CHECK_EN  when defined, HIT compares accu >= acc_rng and misses
//                      are possible. When undefined, every move hits,
//                      last_miss stays 0 and accu/acc_rng are ignored.
// -----------------------------------------------------------------------------
module pbs_turn_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int TURN_W        = 5,
  parameter int MAX_TURNS     = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [4:0]        accu,
  input  logic [4:0]        acc_rng,
  input  logic [4:0]        p_hp,
  input  logic [4:0]        ai_hp,
  output logic              actr,
  output logic              target,
  output logic              app_dmg,
  output logic              stop,
  output logic              busy,
  output logic              last_miss,
  output logic [TURN_W-1:0] turn_cnt,
  output logic              p_win,
  output logic              ai_win,
  output logic              draw
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_P_SEL   = 4'd1,
    S_P_WAIT  = 4'd2,
    S_P_HIT   = 4'd3,
    S_P_APPLY = 4'd4,
    S_P_CHK   = 4'd5,
    S_A_SEL   = 4'd6,
    S_A_WAIT  = 4'd7,
    S_A_HIT   = 4'd8,
    S_A_APPLY = 4'd9,
    S_A_CHK   = 4'd10,
    S_OVER    = 4'd11
  } state_e;

  // The wait counter is loaded with SETTLE_CYCLES-1 and counts down to 0.
  // This gives exactly SETTLE_CYCLES cycles in every WAIT and CHK state.
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [TURN_W-1:0] MAX_T       = TURN_W'(MAX_TURNS);
  localparam logic [TURN_W-1:0] TURN_ONE    = TURN_W'(1);

  state_e              state_q, state_d;
  logic                go_q;
  logic                go_arm_q;
  logic [3:0]          wait_q, wait_d;
  logic                last_miss_q, last_miss_d;
  logic [TURN_W-1:0]   turn_q, turn_d;
  logic                p_win_q, p_win_d;
  logic                ai_win_q, ai_win_d;
  logic                draw_q, draw_d;
  logic                target_q, target_d;
  logic                actr_q, actr_d;

  logic                go_edge;
  logic                hit;
  logic                wait_done;
  logic [TURN_W-1:0]   turn_inc;

  // A rising edge only counts after go has been seen low at least once since
  // reset. Without this, a go held high through reset would look like a
  // fresh edge, because go_q is cleared by reset.
  assign go_edge   = go & ~go_q & go_arm_q;
  assign wait_done = (wait_q == 4'd0);
  assign turn_inc  = turn_q + TURN_ONE;

`ifdef ACCURACY_CHECK_EN
  // Unsigned 5-bit compare. acc_rng never exceeds 15.
  assign hit = (accu >= acc_rng);
`else
  logic unused_acc;
  assign unused_acc = ^{accu, acc_rng};
  assign hit        = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // State and registered flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      go_q        <= 1'b0;
      go_arm_q    <= 1'b0;
      wait_q      <= 4'd0;
      last_miss_q <= 1'b0;
      turn_q      <= '0;
      p_win_q     <= 1'b0;
      ai_win_q    <= 1'b0;
      draw_q      <= 1'b0;
      target_q    <= 1'b0;
      actr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      go_q        <= go;
      if (!go) begin
        go_arm_q  <= 1'b1;
      end
      wait_q      <= wait_d;
      last_miss_q <= last_miss_d;
      turn_q      <= turn_d;
      p_win_q     <= p_win_d;
      ai_win_q    <= ai_win_d;
      draw_q      <= draw_d;
      target_q    <= target_d;
      actr_q      <= actr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // target and actr change when a SEL state is entered. This keeps target
  // steady for the whole half-turn, including the cycle before app_dmg.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    last_miss_d = last_miss_q;
    turn_d      = turn_q;
    p_win_d     = p_win_q;
    ai_win_d    = ai_win_q;
    draw_d      = draw_q;
    target_d    = target_q;
    actr_d      = actr_q;

    unique case (state_q)
      S_IDLE: begin
        actr_d = 1'b0;
        if (go_edge) begin
          state_d  = S_P_SEL;
          target_d = 1'b1;
          actr_d   = 1'b0;
        end
      end

      // ----------------------------- player half ----------------------------
      S_P_SEL: begin
        state_d = S_P_WAIT;
        wait_d  = SETTLE_LAST;
      end

      S_P_WAIT: begin
        if (wait_done) begin
          state_d = S_P_HIT;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      S_P_HIT: begin
        last_miss_d = ~hit;
        if (hit) begin
          state_d = S_P_APPLY;
        end else begin
          // A miss skips the player's faint check and hands over to the AI.
          state_d  = S_A_SEL;
          target_d = 1'b0;
          actr_d   = 1'b1;
        end
      end

      S_P_APPLY: begin
        state_d = S_P_CHK;
        wait_d  = SETTLE_LAST;
      end

      S_P_CHK: begin
        if (wait_done) begin
          if (ai_hp == 5'd0) begin
            state_d = S_OVER;
            p_win_d = 1'b1;
          end else begin
            state_d  = S_A_SEL;
            target_d = 1'b0;
            actr_d   = 1'b1;
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      // ------------------------------ AI half -------------------------------
      S_A_SEL: begin
        state_d = S_A_WAIT;
        wait_d  = SETTLE_LAST;
      end

      S_A_WAIT: begin
        if (wait_done) begin
          state_d = S_A_HIT;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      S_A_HIT: begin
        last_miss_d = ~hit;
        if (hit) begin
          state_d = S_A_APPLY;
        end else begin
          // An AI miss ends the turn without a faint check.
          turn_d = turn_inc;
          if (turn_inc == MAX_T) begin
            state_d = S_OVER;
            draw_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
            actr_d  = 1'b0;
          end
        end
      end

      S_A_APPLY: begin
        state_d = S_A_CHK;
        wait_d  = SETTLE_LAST;
      end

      S_A_CHK: begin
        if (wait_done) begin
          if (p_hp == 5'd0) begin
            state_d  = S_OVER;
            ai_win_d = 1'b1;
          end else begin
            turn_d = turn_inc;
            if (turn_inc == MAX_T) begin
              state_d = S_OVER;
              draw_d  = 1'b1;
            end else begin
              state_d = S_IDLE;
              actr_d  = 1'b0;
            end
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      // Terminal: only reset leaves OVER.
      S_OVER: begin
        state_d = S_OVER;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from the state register
  // ---------------------------------------------------------------------------
  always_comb begin
    busy    = (state_q != S_IDLE) && (state_q != S_OVER);
    app_dmg = (state_q == S_P_APPLY) || (state_q == S_A_APPLY);
  end

  // The RNGs stay frozen from P_SEL through A_CHK, which is exactly busy.
  assign stop      = busy;
  assign actr      = actr_q;
  assign target    = target_q;
  assign last_miss = last_miss_q;
  assign turn_cnt  = turn_q;
  assign p_win     = p_win_q;
  assign ai_win    = ai_win_q;
  assign draw      = draw_q;

endmodule

// File: tb/tb_pbs_turn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pbs_turn_ctrl
//
// Directed and randomized bench for pbs_turn_ctrl. The reference model
// describes each turn by half-turn lengths, pulse offsets and game outcome,
// computed from the sequencing rules.
// -----------------------------------------------------------------------------
module tb_pbs_turn_ctrl;

  localparam int S  = 2;
  localparam int TW = 5;
  localparam int MT = 3;
`ifdef ACCURACY_CHECK_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          go = 1'b0;
  logic [4:0]    accu = '0;
  logic [4:0]    acc_rng = '0;
  logic [4:0]    p_hp = 5'd15;
  logic [4:0]    ai_hp = 5'd15;
  logic          actr, target, app_dmg, stop, busy, last_miss;
  logic [TW-1:0] turn_cnt;
  logic          p_win, ai_win, draw;

  int checks = 0;
  int errors = 0;

  // Reference model state, persistent across turns of one game.
  int m_turns;
  bit m_over, m_pwin, m_aiwin, m_draw, m_lmiss;

  pbs_turn_ctrl #(
    .SETTLE_CYCLES(S),
    .TURN_W(TW),
    .MAX_TURNS(MT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .go(go),
    .accu(accu),
    .acc_rng(acc_rng),
    .p_hp(p_hp),
    .ai_hp(ai_hp),
    .actr(actr),
    .target(target),
    .app_dmg(app_dmg),
    .stop(stop),
    .busy(busy),
    .last_miss(last_miss),
    .turn_cnt(turn_cnt),
    .p_win(p_win),
    .ai_win(ai_win),
    .draw(draw)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_turns = 0;
    m_over  = 0;
    m_pwin  = 0;
    m_aiwin = 0;
    m_draw  = 0;
    m_lmiss = 0;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_turn_cnt"}, 32'(turn_cnt), 32'(m_turns));
    check({tag, "_p_win"}, 32'(p_win), 32'(m_pwin));
    check({tag, "_ai_win"}, 32'(ai_win), 32'(m_aiwin));
    check({tag, "_draw"}, 32'(draw), 32'(m_draw));
    check({tag, "_last_miss"}, 32'(last_miss), 32'(m_lmiss));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset(input logic go_val);
    rst = 1'b1;
    go  = go_val;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Run one go edge and compare the whole turn against the model.
  task automatic play_turn(input int a, input int r, input int ph, input int ah,
                           input bit kill_ai, input bit kill_p, input bit hold_go,
                           input string tag);
    bit pl_hit, ai_hit, pwin, ai_exec, aiwin;
    int ek1, ek2, plen, alen, k_end, ok1, ok2, npul, exp_pul;
    logic ok1_actr, ok2_actr;
    bit stop_bad, seen_busy;

    accu    = 5'(a);
    acc_rng = 5'(r);
    p_hp    = 5'(ph);
    ai_hp   = 5'(ah);
    go      = 1'b0;
    @(negedge clk);
    go = 1'b1;

    if (m_over) begin
      // OVER ignores go: nothing may move.
      seen_busy = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (busy || app_dmg) seen_busy = 1;
      end
      go = 1'b0;
      check({tag, "_over_go_ignored"}, 32'(seen_busy), 32'd0);
      check_flags(tag);
      $display("turn %s over: go ignored turn_cnt=%0d p_win=%0b ai_win=%0b draw=%0b",
               tag, turn_cnt, p_win, ai_win, draw);
      return;
    end

    // Reference: timing and outcome from half-turn lengths.
    pl_hit  = ACC_EN ? (5'(a) >= 5'(r)) : 1'b1;
    ai_hit  = pl_hit;
    plen    = pl_hit ? (2 * S + 3) : (S + 2);
    ek1     = pl_hit ? (S + 3) : 0;
    pwin    = pl_hit && (kill_ai || (5'(ah) == 5'd0));
    ai_exec = !pwin;
    alen    = ai_exec ? (ai_hit ? (2 * S + 3) : (S + 2)) : 0;
    ek2     = (ai_exec && ai_hit) ? (plen + S + 3) : 0;
    aiwin   = ai_exec && ai_hit && (kill_p || (5'(ph) == 5'd0));
    exp_pul = (ek1 != 0 ? 1 : 0) + (ek2 != 0 ? 1 : 0);

    k_end = 0; ok1 = 0; ok2 = 0; npul = 0; stop_bad = 0;
    ok1_actr = 1'bx; ok2_actr = 1'bx;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (!hold_go && k == 2) go = 1'b0;
      if (app_dmg) begin
        npul++;
        if (target) begin
          ok1 = k; ok1_actr = actr;
          if (kill_ai) ai_hp = 5'd0;
        end else begin
          ok2 = k; ok2_actr = actr;
          if (kill_p) p_hp = 5'd0;
        end
      end
      if (busy && !stop) stop_bad = 1;
      if (!busy) begin
        k_end = k;
        break;
      end
    end

    // Update the model for the end of this turn.
    if (pwin) begin
      m_over = 1; m_pwin = 1;
    end else if (aiwin) begin
      m_over = 1; m_aiwin = 1;
    end else begin
      m_turns++;
      if (m_turns == MT) begin
        m_over = 1; m_draw = 1;
      end
    end
    m_lmiss = ACC_EN ? (ai_exec ? !ai_hit : !pl_hit) : 1'b0;

    check({tag, "_end_cycle"}, 32'(k_end), 32'(plen + alen + 1));
    check({tag, "_pulses"}, 32'(npul), 32'(exp_pul));
    check({tag, "_p_pulse_at"}, 32'(ok1), 32'(ek1));
    check({tag, "_a_pulse_at"}, 32'(ok2), 32'(ek2));
    if (ek1 != 0) check({tag, "_p_pulse_actr"}, 32'(ok1_actr), 32'd0);
    if (ek2 != 0) check({tag, "_a_pulse_actr"}, 32'(ok2_actr), 32'd1);
    check({tag, "_stop_while_busy"}, 32'(stop_bad), 32'd0);
    check({tag, "_app_dmg_idle"}, 32'(app_dmg), 32'd0);
    if (!m_over) check({tag, "_stop_idle"}, 32'(stop), 32'd0);
    check_flags(tag);

    if (hold_go) begin
      // A go held high must not start another turn.
      seen_busy = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (busy) seen_busy = 1;
      end
      check({tag, "_no_retrigger"}, 32'(seen_busy), 32'd0);
    end
    go = 1'b0;

    $display("turn %s accu=%0d rng=%0d p_hp=%0d ai_hp=%0d pulses=%0d end=%0d turn_cnt=%0d p_win=%0b ai_win=%0b draw=%0b",
             tag, a, r, ph, ah, npul, k_end, turn_cnt, p_win, ai_win, draw);
  endtask

  initial begin
    bit seen;
    bool_dummy_init();

    // 1: reset with go high; nothing starts until go falls and rises.
    do_reset(1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_actr", 32'(actr), 32'd0);
    check("rst_target", 32'(target), 32'd0);
    check("rst_app_dmg", 32'(app_dmg), 32'd0);
    check("rst_stop", 32'(stop), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_last_miss", 32'(last_miss), 32'd0);
    check("rst_turn_cnt", 32'(turn_cnt), 32'd0);
    check("rst_p_win", 32'(p_win), 32'd0);
    check("rst_ai_win", 32'(ai_win), 32'd0);
    check("rst_draw", 32'(draw), 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    check("rst_go_held_no_start", 32'(seen), 32'd0);
    $display("reset with go held: busy_seen=%0b", seen);

    // 2..5: hit turn, miss turn (or hit when the check is disabled), draw.
    play_turn(16, 5, 15, 15, 0, 0, 1, "t2_hit");
    play_turn(3, 9, 15, 15, 0, 0, 0, "t3_miss");
    play_turn(16, 5, 15, 15, 0, 0, 0, "t5_draw");
    play_turn(16, 5, 15, 15, 0, 0, 0, "t5_after");

    // 4: AI faints after the player apply.
    do_reset(1'b0);
    play_turn(16, 5, 15, 15, 1, 0, 0, "t4_pwin");
    play_turn(16, 5, 15, 15, 0, 0, 0, "t4_after");

    // 6: reset during A_APPLY.
    do_reset(1'b0);
    play_turn(16, 5, 15, 15, 0, 0, 0, "t6_pre");
    go = 1'b0;
    @(negedge clk);
    go = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (app_dmg && !target) begin
        seen = 1;
        break;
      end
    end
    check("t6_reached_a_apply", 32'(seen), 32'd1);
    rst = 1'b1;
    go  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("t6_app_dmg", 32'(app_dmg), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_turn_cnt", 32'(turn_cnt), 32'd0);
    check("t6_stop", 32'(stop), 32'd0);
    $display("reset in A_APPLY: app_dmg=%0b busy=%0b turn_cnt=%0d", app_dmg, busy, turn_cnt);

    // Randomized games.
    for (int g = 0; g < 30; g++) begin
      do_reset(1'b0);
      for (int t = 0; t < 5; t++) begin
        int ra, rr, rph, rah;
        ra  = $urandom_range(0, 31);
        rr  = $urandom_range(0, 15);
        rph = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31);
        rah = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31);
        play_turn(ra, rr, rph, rah, ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                  $urandom_range(0, 1) == 1, $sformatf("g%0d_t%0d", g, t));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic bool_dummy_init();
    model_reset();
  endtask

endmodule
